// File: rtl/tile_renderer_pkg.sv
// tile_renderer_pkg: shared types and defaults for the tile-grid renderer.
//   rgb12_t      - 12-bit {r,g,b} colour.
//   tile_coord_t - per-pixel tile coordinates handed from stage 1 to stage 2.
//   *_DEFAULT    - default tile edge and grid dimensions.
// Optional macro TILE_RENDERER_GRID_EN adds the sub-tile zero flags that the
// grid overlay needs.
package tile_renderer_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int TILE_DEFAULT = 40;
  localparam int COLS_DEFAULT = 16;
  localparam int ROWS_DEFAULT = 12;

  // Width of every tile/sub-tile counter; generous so tile_x never wraps
  // on any realistic line length.
  localparam int COORD_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] tile_x;
    logic [COORD_W-1:0] tile_y;
`ifdef TILE_RENDERER_GRID_EN
    logic               sub_x_zero;
    logic               sub_y_zero;
`endif
  } tile_coord_t;

endpackage

// File: rtl/tile_renderer_tile_counter.sv
// tile_counter: one sub-tile / tile counter pair for a single screen axis.
// Outputs are the coordinates of the *current* cycle (clear and advance are
// applied combinationally), so a clear pulse on a pixel makes that very pixel
// coordinate 0.
// Ports:
//   clk, rst   - pixel clock, asynchronous active-high reset
//   clear      - force sub/tile to 0 (wins over advance, ignores enable)
//   advance    - step sub by one, wrapping at TILE and bumping tile
//   enable     - qualifies advance; counters hold while low
//   sub, tile  - current sub-tile and tile coordinate
module tile_counter
  import tile_renderer_pkg::*;
#(
  parameter int TILE = TILE_DEFAULT,
  parameter int W    = COORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  input  logic         enable,
  output logic [W-1:0] sub,
  output logic [W-1:0] tile
);

  logic [W-1:0] sub_q, sub_d;
  logic [W-1:0] tile_q, tile_d;

  always_comb begin
    sub_d  = sub_q;
    tile_d = tile_q;
    if (clear) begin
      sub_d  = '0;
      tile_d = '0;
    end else if (advance && enable) begin
      if (sub_q == W'(TILE - 1)) begin
        sub_d  = '0;
        tile_d = tile_q + W'(1);
      end else begin
        sub_d = sub_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q  <= '0;
      tile_q <= '0;
    end else begin
      sub_q  <= sub_d;
      tile_q <= tile_d;
    end
  end

  assign sub  = sub_d;
  assign tile = tile_d;

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: two-stage tile-grid pixel renderer between VGA timing and DAC.
//   Stage 1 registers the tile coordinates of the pixel plus de.
//   Stage 2 registers the priority-selected colour; rgb/rgb_valid lag de by 2.
// Game state is captured into shadow registers on frame_start so the
// playfield never tears mid-frame.
// Ports:
//   clk, rst                      - pixel clock, asynchronous active-high reset
//   de, line_start, frame_start   - timing-generator strobes
//   player_row                    - player tile row
//   bullet_rgb/col/row            - per-slot projectile colour and position
//   enemy_rgb                     - E_ROWS x E_COLS enemy colours (0 = dead)
//   rgb, rgb_valid                - registered pixel colour and its qualifier
// Optional macro: TILE_RENDERER_GRID_EN draws GRID_RGB on sub-tile 0 lines
// for tile_x >= 1.
module tile_renderer
  import tile_renderer_pkg::*;
#(
  parameter int          TILE      = TILE_DEFAULT,
  parameter int          COLS      = COLS_DEFAULT,
  parameter int          ROWS      = ROWS_DEFAULT,
  parameter int          N_BULLETS = 3,
  parameter int          E_ROWS    = 5,
  parameter int          E_COLS    = 6,
  parameter int          E_COL0    = 4,
  parameter logic [11:0] HOME_RGB  = 12'h282,
  parameter logic [11:0] GRID_RGB  = 12'h111
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         de,
  input  logic                         line_start,
  input  logic                         frame_start,
  input  logic [3:0]                   player_row,
  input  logic [N_BULLETS*12-1:0]      bullet_rgb,
  input  logic [N_BULLETS*4-1:0]       bullet_col,
  input  logic [N_BULLETS*4-1:0]       bullet_row,
  input  logic [E_ROWS*E_COLS*12-1:0]  enemy_rgb,
  output logic [11:0]                  rgb,
  output logic                         rgb_valid
);

  localparam logic [COORD_W-1:0] COLS_W      = COORD_W'(COLS);
  localparam logic [COORD_W-1:0] ROWS_W      = COORD_W'(ROWS);
  localparam logic [COORD_W-1:0] E_ROWS_W    = COORD_W'(E_ROWS);
  localparam logic [COORD_W-1:0] E_COLS_W    = COORD_W'(E_COLS);
  localparam logic [COORD_W-1:0] E_COL0_W    = COORD_W'(E_COL0);
  localparam logic [COORD_W-1:0] E_COL0_HALF = COORD_W'(E_COL0 / 2);

  // ---------------- tile counters ----------------
  logic [COORD_W-1:0] sub_x, tile_x, sub_y, tile_y;

  tile_counter #(.TILE(TILE), .W(COORD_W)) u_x_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (line_start | frame_start),
    .advance (1'b1),
    .enable  (de),
    .sub     (sub_x),
    .tile    (tile_x)
  );

  tile_counter #(.TILE(TILE), .W(COORD_W)) u_y_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (frame_start),
    .advance (line_start),
    .enable  (de),
    .sub     (sub_y),
    .tile    (tile_y)
  );

  // ---------------- shadow game state ----------------
  // Loaded on the frame_start edge. The frame_start pixel itself is always
  // at tile (0,0), i.e. homeworld, whose colour does not depend on any
  // shadowed state, so it renders as if it used the previous shadow.
  logic [3:0]                  player_row_q, player_row_d;
  logic [N_BULLETS*12-1:0]     bullet_rgb_q, bullet_rgb_d;
  logic [N_BULLETS*4-1:0]      bullet_col_q, bullet_col_d;
  logic [N_BULLETS*4-1:0]      bullet_row_q, bullet_row_d;
  logic [E_ROWS*E_COLS*12-1:0] enemy_rgb_q, enemy_rgb_d;

  always_comb begin
    player_row_d = player_row_q;
    bullet_rgb_d = bullet_rgb_q;
    bullet_col_d = bullet_col_q;
    bullet_row_d = bullet_row_q;
    enemy_rgb_d  = enemy_rgb_q;
    if (frame_start) begin
      player_row_d = player_row;
      bullet_rgb_d = bullet_rgb;
      bullet_col_d = bullet_col;
      bullet_row_d = bullet_row;
      enemy_rgb_d  = enemy_rgb;
    end
  end

  // ---------------- stage 1: coordinates ----------------
  tile_coord_t coord_q, coord_d;
  logic        de_q, de_d;

  always_comb begin
    coord_d        = '0;
    coord_d.tile_x = tile_x;
    coord_d.tile_y = tile_y;
`ifdef TILE_RENDERER_GRID_EN
    coord_d.sub_x_zero = (sub_x == '0);
    coord_d.sub_y_zero = (sub_y == '0);
`endif
    de_d = de;
  end

`ifndef TILE_RENDERER_GRID_EN
  // Sub-tile positions and GRID_RGB only feed the grid overlay.
  logic unused_grid;
  assign unused_grid = ^{sub_x, sub_y, GRID_RGB};
`endif

  // ---------------- stage 2: priority colour ----------------
  // Bullet matches per slot. Grid bounds are enforced once on the pixel,
  // so a matching bullet is necessarily inside the grid.
  logic [N_BULLETS-1:0] bullet_hit;
  rgb12_t               bullet_colour [N_BULLETS];

  for (genvar gi = 0; gi < N_BULLETS; gi++) begin : g_bullet
    logic [3:0] slot_col, slot_row;
    assign bullet_colour[gi] = bullet_rgb_q[gi*12 +: 12];
    assign slot_col          = bullet_col_q[gi*4 +: 4];
    assign slot_row          = bullet_row_q[gi*4 +: 4];
    assign bullet_hit[gi]    = (bullet_colour[gi] != '0) &&
                               ({4'd0, slot_col} == coord_q.tile_x) &&
                               ({4'd0, slot_row} == coord_q.tile_y);
  end

  rgb12_t             rgb_q, rgb_d;
  logic               rgb_valid_q, rgb_valid_d;
  rgb12_t             bullet_sel, enemy_sel;
  logic               bullet_any, enemy_ok;
  logic [COORD_W-1:0] enemy_r, enemy_c;

  always_comb begin
    bullet_any = 1'b0;
    bullet_sel = '0;
    // Walk high to low so the lowest-index hit is the one left standing.
    for (int k = N_BULLETS - 1; k >= 0; k--) begin
      if (bullet_hit[k]) begin
        bullet_any = 1'b1;
        bullet_sel = bullet_colour[k];
      end
    end

    enemy_r   = coord_q.tile_y >> 1;
    enemy_c   = (coord_q.tile_x >> 1) - E_COL0_HALF;
    enemy_ok  = coord_q.tile_y[0] && !coord_q.tile_x[0] &&
                (coord_q.tile_x >= E_COL0_W) &&
                (enemy_r < E_ROWS_W) && (enemy_c < E_COLS_W);
    enemy_sel = '0;
    for (int er = 0; er < E_ROWS; er++) begin
      for (int ec = 0; ec < E_COLS; ec++) begin
        if (enemy_r == COORD_W'(er) && enemy_c == COORD_W'(ec)) begin
          enemy_sel = enemy_rgb_q[(er*E_COLS + ec)*12 +: 12];
        end
      end
    end

    rgb_valid_d = de_q;
    rgb_d       = '0;
    if (!de_q || coord_q.tile_x >= COLS_W || coord_q.tile_y >= ROWS_W) begin
      rgb_d = '0;
    end else if (coord_q.tile_x == '0) begin
      rgb_d = HOME_RGB;
`ifdef TILE_RENDERER_GRID_EN
    end else if (coord_q.sub_x_zero || coord_q.sub_y_zero) begin
      rgb_d = GRID_RGB;
`endif
    end else if (coord_q.tile_x == COORD_W'(1) &&
                 coord_q.tile_y == {4'd0, player_row_q}) begin
      rgb_d = 12'hFFF;
    end else if (bullet_any) begin
      rgb_d = bullet_sel;
    end else if (enemy_ok) begin
      rgb_d = enemy_sel;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      player_row_q <= '0;
      bullet_rgb_q <= '0;
      bullet_col_q <= '0;
      bullet_row_q <= '0;
      enemy_rgb_q  <= '0;
      coord_q      <= '0;
      de_q         <= 1'b0;
      rgb_q        <= '0;
      rgb_valid_q  <= 1'b0;
    end else begin
      player_row_q <= player_row_d;
      bullet_rgb_q <= bullet_rgb_d;
      bullet_col_q <= bullet_col_d;
      bullet_row_q <= bullet_row_d;
      enemy_rgb_q  <= enemy_rgb_d;
      coord_q      <= coord_d;
      de_q         <= de_d;
      rgb_q        <= rgb_d;
      rgb_valid_q  <= rgb_valid_d;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_tile_renderer.sv
// tb_tile_renderer: directed self-checking bench for tile_renderer.
// Pixels are reached cheaply by issuing one-pixel lines (line_start pulses)
// to walk down, then a run of de pixels to walk across.
module tb_tile_renderer;

  localparam int N_BULLETS = 3;
  localparam int E_ROWS    = 5;
  localparam int E_COLS    = 6;
`ifdef TILE_RENDERER_GRID_EN
  localparam bit GRID_ON = 1'b1;
`else
  localparam bit GRID_ON = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        de = 1'b0;
  logic                        line_start = 1'b0;
  logic                        frame_start = 1'b0;
  logic [3:0]                  player_row = 4'd3;
  logic [N_BULLETS*12-1:0]     bullet_rgb = '0;
  logic [N_BULLETS*4-1:0]      bullet_col = '0;
  logic [N_BULLETS*4-1:0]      bullet_row = '0;
  logic [E_ROWS*E_COLS*12-1:0] enemy_rgb = '0;
  logic [11:0]                 rgb;
  logic                        rgb_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start),
    .player_row  (player_row),
    .bullet_rgb  (bullet_rgb),
    .bullet_col  (bullet_col),
    .bullet_row  (bullet_row),
    .enemy_rgb   (enemy_rgb),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid)
  );

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic drive(input logic d, input logic ls, input logic fs);
    de = d; line_start = ls; frame_start = fs;
    @(posedge clk); #1;
    de = 1'b0; line_start = 1'b0; frame_start = 1'b0;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
  endtask

  // New frame (shadow reload), walk to (x,y), flush into stage 2.
  task automatic render(input int x, input int y, output logic [11:0] got, output logic got_v);
    drive(1'b1, 1'b1, 1'b1);
    lines(y);
    pixels(x);
    drive(1'b0, 1'b0, 1'b0);
    got = rgb; got_v = rgb_valid;
    $display("pixel (%0d,%0d) rgb=%h valid=%b", x, y, got, got_v);
  endtask

  function automatic logic [11:0] row3_colour(input int px);
    if (px < 40) return 12'h282;
    if (GRID_ON && (px % 40) == 0) return 12'h111;
    return 12'hFFF;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: rgb=%h expected 000", rgb); end
    checks++;
    if (rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: valid=%b expected 0", rgb_valid); end
    rst = 1'b0;
    // No frame_start: shadow player_row must still be the reset value 0.
    drive(1'b1, 1'b1, 1'b0);                // pixel (0,1)
    checks++;
    if (rgb_valid !== 1'b0) begin errors++; $display("FAIL latency_1clk: valid=%b expected 0", rgb_valid); end
    drive(1'b1, 1'b0, 1'b0);                // pixel (1,1)
    checks++;
    if ({rgb_valid, rgb} !== {1'b1, 12'h282}) begin
      errors++; $display("FAIL latency_2clk: rgb=%h valid=%b expected 282/1", rgb, rgb_valid);
    end
    pixels(44);                             // up to pixel (45,1)
    drive(1'b0, 1'b0, 1'b0);
    $display("pixel (45,1) rgb=%h valid=%b", rgb, rgb_valid);
    checks++;
    if ({rgb_valid, rgb} !== {1'b1, 12'hFFF}) begin
      errors++; $display("FAIL shadow_reset_row0: rgb=%h valid=%b expected FFF/1", rgb, rgb_valid);
    end
  endtask

  task automatic test_home_player();
    logic [11:0] got; logic v;
    player_row = 4'd3;
    render(20, 130, got, v); checks++;
    if ({v, got} !== {1'b1, 12'h282}) begin errors++; $display("FAIL home_20_130: rgb=%h valid=%b expected 282/1", got, v); end
    render(60, 130, got, v); checks++;
    if ({v, got} !== {1'b1, 12'hFFF}) begin errors++; $display("FAIL player_60_130: rgb=%h valid=%b expected FFF/1", got, v); end
    render(60, 170, got, v); checks++;
    if ({v, got} !== {1'b1, 12'h000}) begin errors++; $display("FAIL empty_60_170: rgb=%h valid=%b expected 000/1", got, v); end
  endtask

  task automatic test_bullets();
    logic [11:0] got; logic v;
    bullet_rgb = {12'h000, 12'h0F0, 12'hF00};
    bullet_col = {4'd7, 4'd5, 4'd5};
    bullet_row = {4'd2, 4'd2, 4'd2};
    render(210, 90, got, v); checks++;
    if ({v, got} !== {1'b1, 12'hF00}) begin errors++; $display("FAIL bullet_slot0: rgb=%h valid=%b expected F00/1", got, v); end
    render(290, 90, got, v); checks++;
    if ({v, got} !== {1'b1, 12'h000}) begin errors++; $display("FAIL bullet_empty_slot: rgb=%h valid=%b expected 000/1", got, v); end
    bullet_rgb[11:0] = 12'h000;             // slot 0 empty: slot 1 takes over
    render(210, 90, got, v); checks++;
    if ({v, got} !== {1'b1, 12'h0F0}) begin errors++; $display("FAIL bullet_slot1: rgb=%h valid=%b expected 0F0/1", got, v); end
    bullet_rgb[11:0] = 12'hF00;
  endtask

  task automatic test_enemies();
    logic [11:0] got; logic v;
    enemy_rgb = '0;
    enemy_rgb[(2*E_COLS + 3)*12 +: 12] = 12'h0AF;
    render(400, 210, got, v); checks++;
    if ({v, got} !== {1'b1, (GRID_ON ? 12'h111 : 12'h0AF)}) begin
      errors++; $display("FAIL enemy_10_5: rgb=%h valid=%b expected %h/1", got, v, (GRID_ON ? 12'h111 : 12'h0AF));
    end
    render(400, 250, got, v); checks++;
    if ({v, got} !== {1'b1, (GRID_ON ? 12'h111 : 12'h000)}) begin
      errors++; $display("FAIL enemy_even_row: rgb=%h valid=%b expected %h/1", got, v, (GRID_ON ? 12'h111 : 12'h000));
    end
  endtask

  task automatic test_bounds();
    logic [11:0] got; logic v;
    render(20, 480, got, v); checks++;      // tile_y = 12 = ROWS
    if ({v, got} !== {1'b1, 12'h000}) begin errors++; $display("FAIL row_out_of_range: rgb=%h valid=%b expected 000/1", got, v); end
  endtask

  task automatic test_tearing();
    logic [11:0] got; logic v;
    player_row = 4'd3;
    drive(1'b1, 1'b1, 1'b1);
    player_row = 4'd7;                      // mid-frame change
    lines(130); pixels(60); drive(1'b0, 1'b0, 1'b0);
    $display("pixel (60,130) rgb=%h valid=%b", rgb, rgb_valid);
    checks++;
    if ({rgb_valid, rgb} !== {1'b1, 12'hFFF}) begin errors++; $display("FAIL tear_row3_old: rgb=%h valid=%b expected FFF/1", rgb, rgb_valid); end
    lines(160); pixels(60); drive(1'b0, 1'b0, 1'b0);
    $display("pixel (60,290) rgb=%h valid=%b", rgb, rgb_valid);
    checks++;
    if ({rgb_valid, rgb} !== {1'b1, 12'h000}) begin errors++; $display("FAIL tear_row7_old: rgb=%h valid=%b expected 000/1", rgb, rgb_valid); end
    render(60, 130, got, v); checks++;
    if ({v, got} !== {1'b1, 12'h000}) begin errors++; $display("FAIL tear_row3_new: rgb=%h valid=%b expected 000/1", got, v); end
    render(60, 290, got, v); checks++;
    if ({v, got} !== {1'b1, 12'hFFF}) begin errors++; $display("FAIL tear_row7_new: rgb=%h valid=%b expected FFF/1", got, v); end
  endtask

  task automatic test_frame_start_idle();
    drive(1'b1, 1'b1, 1'b1); lines(300); pixels(100);   // leave counters non-zero
    player_row = 4'd5;
    drive(1'b0, 1'b0, 1'b1);                // frame_start with de low
    player_row = 4'd0;
    lines(210); pixels(60); drive(1'b0, 1'b0, 1'b0);
    $display("pixel (60,210) rgb=%h valid=%b", rgb, rgb_valid);
    checks++;
    if ({rgb_valid, rgb} !== {1'b1, 12'hFFF}) begin
      errors++; $display("FAIL fs_without_de: rgb=%h valid=%b expected FFF/1", rgb, rgb_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] prev_exp, cur_exp;
    logic        d;
    int          px;
    player_row = 4'd3;
    drive(1'b1, 1'b1, 1'b1);
    lines(130);                             // pixel (0,130) now in stage 1
    px = 1;
    prev_exp = {1'b1, 12'h282};
    // 38 pixels, 4-cycle de gap, 5 pixels across the tile edge, 2 idle.
    for (int s = 0; s < 49; s++) begin
      d = (s < 38) || (s >= 42 && s < 47);
      if (d) begin cur_exp = {1'b1, row3_colour(px)}; px++; end
      else cur_exp = 13'h0;
      drive(d, 1'b0, 1'b0);
      $display("stream step %0d rgb=%h valid=%b", s, rgb, rgb_valid);
      checks++;
      if ({rgb_valid, rgb} !== prev_exp) begin
        errors++; $display("FAIL stream_step_%0d: rgb=%h valid=%b expected %h/%b", s, rgb, rgb_valid, prev_exp[11:0], prev_exp[12]);
      end
      prev_exp = cur_exp;
    end
  endtask

  task automatic test_grid();
    logic [11:0] got; logic v;
    render(80, 85, got, v); checks++;
    if ({v, got} !== {1'b1, (GRID_ON ? 12'h111 : 12'h000)}) begin
      errors++; $display("FAIL grid_80_85: rgb=%h valid=%b expected %h/1", got, v, (GRID_ON ? 12'h111 : 12'h000));
    end
    render(0, 0, got, v); checks++;
    if ({v, got} !== {1'b1, 12'h282}) begin errors++; $display("FAIL home_0_0: rgb=%h valid=%b expected 282/1", got, v); end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 1'b1, 1'b1); pixels(5);     // pipeline full of valid pixels
    rst = 1'b1;
    #1;
    checks++;
    if (rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb: rgb=%h expected 000", rgb); end
    checks++;
    if (rgb_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: valid=%b expected 0", rgb_valid); end
    #2 rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if ({rgb_valid, rgb} !== {1'b0, 12'h000}) begin
      errors++; $display("FAIL midreset_hold: rgb=%h valid=%b expected 000/0", rgb, rgb_valid);
    end
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if ({rgb_valid, rgb} !== {1'b1, 12'h282}) begin
      errors++; $display("FAIL midreset_first_pixel: rgb=%h valid=%b expected 282/1", rgb, rgb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_home_player();
    test_bullets();
    test_enemies();
    test_bounds();
    test_tearing();
    test_frame_start_idle();
    test_back_to_back();
    test_grid();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
# tile_renderer

Parametrised, pipelined tile-grid pixel renderer for the game display. It sits between the VGA timing generator and the DAC pins. Each active pixel is mapped to a tile, the tile is resolved against the game state, and a registered 12-bit RGB value is produced two clocks later. Game state is captured into shadow registers once per frame, so playfield updates never tear mid-frame.

## Interface
Parameters:
- TILE, 40: tile edge in pixels.
- COLS, 16: tile columns.
- ROWS, 12: tile rows.
- N_BULLETS, 3: number of projectile slots.
- E_ROWS, 5: enemy grid rows.
- E_COLS, 6: enemy grid columns.
- E_COL0, 4: first screen column holding enemies.
- HOME_RGB, 12'h282: homeworld column colour.
- GRID_RGB, 12'h111: grid-line colour; used only with the macro in Configuration.

Ports (clock/reset: one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- de  in  1  active-video strobe from the timing generator.
- line_start  in  1  one-cycle pulse on the first active pixel of each line.
- frame_start  in  1  one-cycle pulse on the first active pixel of each frame.
- player_row  in  4  player tile row.
- bullet_rgb  in  N_BULLETS×12  per-slot colour; 0 means the slot is empty.
- bullet_col  in  N_BULLETS×4  per-slot tile column.
- bullet_row  in  N_BULLETS×4  per-slot tile row.
- enemy_rgb  in  E_ROWS×E_COLS×12  enemy colours; 0 means the cell is dead.
- rgb  out  12  pixel colour {r[3:0], g[3:0], b[3:0]}.
- rgb_valid  out  1  `de` delayed to align with `rgb`.

## Operation
- Shadow state: `frame_start` loads all game-state inputs into shadow registers. Rendering always uses the shadow copy.
- The shadow copy becomes visible from the pixel after `frame_start`. The pixel at `frame_start` itself uses the old shadow.
- Tile counters: `sub_x` counts 0..TILE-1, and `tile_x` advances on `sub_x` wrap.
- `line_start` forces `sub_x`/`tile_x` to 0 and advances `sub_y`/`tile_y` the same way, with `sub_y` wrapping at TILE.
- `frame_start` forces all four counters to 0. It takes precedence over `line_start`.
- Counters hold when `de` is low. No divider is used.
- Colour priority, first match wins:
  1. `tile_x`=0 → HOME_RGB.
  2. `tile_x`=1 and `tile_y`=`player_row` → 12'hFFF.
  3. Bullet slot k, lowest index first, with `rgb`≠0 and matching col/row → `bullet_rgb[k]`.
  4. `tile_y` odd, `tile_x` even, `tile_x`≥E_COL0 → `enemy_rgb[tile_y/2][tile_x/2−E_COL0/2]`. Applies only when both indices are in range.
  5. Otherwise 0.
- Out-of-range handling: a `player_row`≥ROWS, a bullet outside the grid, or an enemy index outside the array draws nothing and falls to the next rule.
- `tile_x`≥COLS or `tile_y`≥ROWS → 0.
- Whenever `rgb_valid`=0, `rgb`=0.

## Timing
- Reset values: `rgb`=0, `rgb_valid`=0, all counters 0, all shadow registers 0.
- Pipeline:
  - Stage 1 registers the tile coordinates plus `de`.
  - Stage 2 registers the priority-selected colour.
- Latency: `de` at cycle N → `rgb`/`rgb_valid` at N+2. Throughput is one pixel per clock, with no stalls.
- A `frame_start` pulse arriving with `de`=0 still loads the shadow registers and resets the counters.
- Reset asserted mid-frame clears both pipeline stages immediately. Output is 0 until the next `de`-qualified pixel has traversed both stages.

## Configuration
- Macro: `TILE_RENDERER_GRID_EN`.
  - Defined: a pixel with `sub_x`=0 or `sub_y`=0 and `tile_x`≥1 outputs GRID_RGB. This check sits above rules 2–5; rule 1 (homeworld) is unaffected.
  - Undefined: no grid logic is generated, and GRID_RGB is unused.

## Structure
- Package `tile_renderer_pkg`: `rgb12_t` (logic [11:0]), the struct of per-tile coordinates passed between pipeline stages, and the localparam defaults for TILE/COLS/ROWS.
- Sub-module `tile_counter`: one instance per axis. Each holds a `sub`/`tile` counter pair with `clear`, `advance` and `enable` inputs, parametrised by TILE.
- Shadow registers and the priority mux live in the top module.

## Test plan
- Reset: drive `rst`=1 mid-line → `rgb`=0 and `rgb_valid`=0 on the same edge. After release, the first `de` pixel appears 2 clocks later.
- Homeworld/player: `player_row`=3, latched at `frame_start`.
  - Pixel (20,130) → `rgb`=12'h282.
  - Pixel (60,130) → 12'hFFF.
  - Pixel (60,170) → 0.
- Bullets: slot 0 = (12'hF00, col 5, row 2), slot 1 = (12'h0F0, col 5, row 2), slot 2 `rgb`=0 at col 7 → pixel (210,90)=12'hF00 and pixel (290,90)=0.
- Enemies: `enemy_rgb[2][3]`=12'h0AF → pixel (400,210)=12'h0AF (tile 10,5) and pixel (400,250)=0 (even row).
- Tearing: change `player_row` 3→7 mid-frame → rows 3/7 unchanged until the next `frame_start`, after which row 7 is white and row 3 is black.
- With `TILE_RENDERER_GRID_EN` defined: pixel (80,85)=GRID_RGB and pixel (0,0)=HOME_RGB. Without it: pixel (80,85)=0.
